// File: rtl/c32_pkg.sv
// c32_pkg: shared definitions for the c32 multi-cycle core.
//   - opcode constants (8-bit op field, ir[31:24])
//   - 3-bit ALU operation encoding (selected by op[2:0] of the ALU groups)
//   - FSM state enum
//   - reset vector and a 16->32 sign-extension helper
package c32_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDI = 8'h01;
  localparam logic [7:0] OP_LUI = 8'h02;
  localparam logic [7:0] OP_LD  = 8'h20;
  localparam logic [7:0] OP_ST  = 8'h21;
  localparam logic [7:0] OP_JR  = 8'h30;
  localparam logic [7:0] OP_BEQ = 8'h31;
  localparam logic [7:0] OP_BNE = 8'h32;
  localparam logic [7:0] OP_JAL = 8'h33;
  localparam logic [7:0] OP_MUL = 8'h40;
  localparam logic [7:0] OP_HLT = 8'hFF;

  // op[7:3] group codes: 10..17 register ALU, 18..1F immediate ALU
  localparam logic [4:0] OP_GRP_ALU_R = 5'b00010;
  localparam logic [4:0] OP_GRP_ALU_I = 5'b00011;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SHL = 3'd5,
    ALU_SHR = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_EXEC  = 2'd1,
    ST_MEM   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/c32_alu.sv
// c32_alu: combinational ALU of the c32 core.
// Ports:
//   op  in  3   operation (alu_op_e encoding)
//   x   in  32  first operand (rs)
//   y   in  32  second operand (rt or sign-extended immediate)
//   res out 32  result; shifts use y[4:0], SLT is signed and yields 1/0
module c32_alu
  import c32_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] x,
  input  logic [31:0] y,
  output logic [31:0] res
);

  always_comb begin
    res = '0;
    case (alu_op_e'(op))
      ALU_ADD: res = x + y;
      ALU_SUB: res = x - y;
      ALU_AND: res = x & y;
      ALU_OR:  res = x | y;
      ALU_XOR: res = x ^ y;
      ALU_SHL: res = x << y[4:0];
      ALU_SHR: res = x >> y[4:0];
      ALU_SLT: res = {31'd0, ($signed(x) < $signed(y))};
      default: res = '0;
    endcase
  end

endmodule

// File: rtl/c32_cpu.sv
// c32_cpu: minimal 32-bit multi-cycle processor core.
// One word-wide memory port is shared by instruction fetch and load/store.
// The memory returns read data for address a within the same cycle and
// writes o to address a whenever w is high at a rising edge.
// Ports:
//   clock    in  1   system clock, rising edge
//   reset_n  in  1   synchronous active-low reset (priority over ce)
//   ce       in  1   clock enable; 0 freezes every register and output
//   a        out 32  registered byte address (a[1:0] always 00)
//   i        in  32  read data for the current a
//   o        out 32  registered store data
//   w        out 1   registered write strobe, high for the MEM cycle of a ST
// Optional feature: define C32_MUL_EN to make op 40 a single-cycle MUL
// (rd = low 32 bits of rs*rt); otherwise op 40 is a NOP.
// FSM: FETCH -> EXEC -> (MEM ->) FETCH; HLT parks in HALT until reset.
// The current state is held in state_q (state_e) for inspection.
module c32_cpu
  import c32_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ce,
  output logic [31:0] a,
  input  logic [31:0] i,
  output logic [31:0] o,
  output logic        w
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] a_q, a_d;
  logic [31:0] o_q, o_d;
  logic        w_q, w_d;
  logic [31:0] rf_q [16];
  logic [31:0] rf_d [16];

  // Instruction fields
  logic [7:0]  opc;
  logic [3:0]  rd_idx, rs_idx, rt_idx;
  logic [15:0] imm;
  logic [31:0] simm;
  assign opc    = ir_q[31:24];
  assign rd_idx = ir_q[23:20];
  assign rs_idx = ir_q[19:16];
  assign rt_idx = ir_q[3:0];
  assign imm    = ir_q[15:0];
  assign simm   = sext16(imm);

  // r0 is never written, so reading rf_q[0] always yields 0. Operands are
  // taken from rf_q, i.e. the values before the current instruction.
  logic [31:0] rd_val, rs_val, rt_val;
  assign rd_val = rf_q[rd_idx];
  assign rs_val = rf_q[rs_idx];
  assign rt_val = rf_q[rt_idx];

  logic [31:0] pc_plus4, br_target, ea;
  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + (simm << 2);
  assign ea        = (rs_val + simm) & 32'hFFFF_FFFC;

  logic        is_alu_r, is_alu_i;
  logic [31:0] alu_b, alu_res;
  assign is_alu_r = (opc[7:3] == OP_GRP_ALU_R);
  assign is_alu_i = (opc[7:3] == OP_GRP_ALU_I);
  assign alu_b    = is_alu_i ? simm : rt_val;

  c32_alu u_alu (
    .op  (opc[2:0]),
    .x   (rs_val),
    .y   (alu_b),
    .res (alu_res)
  );

`ifdef C32_MUL_EN
  logic [31:0] mul_res;
  assign mul_res = rs_val * rt_val;
`endif

  // Register write-back request for this cycle
  logic        wb_en;
  logic [31:0] wb_data;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    o_d     = o_q;
    w_d     = 1'b0;
    wb_en   = 1'b0;
    wb_data = '0;

    case (state_q)
      ST_FETCH: begin
        ir_d    = i;
        state_d = ST_EXEC;
      end

      ST_EXEC: begin
        // Default: straight-line instruction, fetch the next word.
        pc_d    = pc_plus4;
        a_d     = pc_plus4;
        state_d = ST_FETCH;
        if (is_alu_r || is_alu_i) begin
          wb_en   = 1'b1;
          wb_data = alu_res;
        end else begin
          case (opc)
            OP_NOP: ;
            OP_LDI: begin
              wb_en   = 1'b1;
              wb_data = simm;
            end
            OP_LUI: begin
              wb_en   = 1'b1;
              wb_data = {imm, 16'h0000};
            end
            // LD/ST keep pc; MEM advances it after the data access.
            OP_LD: begin
              pc_d    = pc_q;
              a_d     = ea;
              state_d = ST_MEM;
            end
            OP_ST: begin
              pc_d    = pc_q;
              a_d     = ea;
              o_d     = rd_val;
              w_d     = 1'b1;
              state_d = ST_MEM;
            end
            OP_JR: begin
              pc_d = ea;
              a_d  = ea;
            end
            OP_BEQ: begin
              if (rd_val == rs_val) begin
                pc_d = br_target;
                a_d  = br_target;
              end
            end
            OP_BNE: begin
              if (rd_val != rs_val) begin
                pc_d = br_target;
                a_d  = br_target;
              end
            end
            OP_JAL: begin
              wb_en   = 1'b1;
              wb_data = pc_plus4;
              pc_d    = br_target;
              a_d     = br_target;
            end
`ifdef C32_MUL_EN
            OP_MUL: begin
              wb_en   = 1'b1;
              wb_data = mul_res;
            end
`else
            OP_MUL: ;
`endif
            OP_HLT: begin
              pc_d    = pc_q;
              a_d     = a_q;
              state_d = ST_HALT;
            end
            default: ;
          endcase
        end
      end

      ST_MEM: begin
        pc_d    = pc_plus4;
        a_d     = pc_plus4;
        state_d = ST_FETCH;
        if (opc == OP_LD) begin
          wb_en   = 1'b1;
          wb_data = i;
        end
      end

      ST_HALT: ;

      default: state_d = ST_FETCH;
    endcase

    rf_d = rf_q;
    if (wb_en && (rd_idx != 4'd0)) rf_d[rd_idx] = wb_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
      pc_q    <= RESET_VECTOR;
      ir_q    <= '0;
      a_q     <= RESET_VECTOR;
      o_q     <= '0;
      w_q     <= 1'b0;
      for (int k = 0; k < 16; k++) rf_q[k] <= '0;
    end else if (ce) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      o_q     <= o_d;
      w_q     <= w_d;
      for (int k = 0; k < 16; k++) rf_q[k] <= rf_d[k];
    end
  end

  assign a = a_q;
  assign o = o_q;
  assign w = w_q;

endmodule

// File: tb/tb_c32_cpu.sv
// tb_c32_cpu: self-checking bench for c32_cpu.
// A 1 KB word memory model serves the shared port. An instruction-level
// reference model executes each program and produces the expected per-cycle
// {a, w, o} sequence (CPI 2, or 3 for LD/ST); the observed sequence is
// compared against it, honouring cycles where ce was held low.
module tb_c32_cpu;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce      = 1'b0;
  logic [31:0] i       = '0;
  logic [31:0] a, o;
  logic        w;

  c32_cpu dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ce      (ce),
    .a       (a),
    .i       (i),
    .o       (o),
    .w       (w)
  );

  always #5 clock = ~clock;

  // ---------------- memory model ----------------
  logic [31:0] mem   [256];
  logic [31:0] m_mem [256];
  logic [31:0] m_reg [16];

  always @(negedge clock) i = mem[a[9:2]];
  always @(posedge clock) if (w === 1'b1) mem[a[9:2]] = o;

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [64:0] exp_q [$];   // {a, w, o}
  logic [64:0] obs_q [$];
  bit          ce_q  [$];   // ce applied at the edge following each sample

  function automatic logic [31:0] ins_i(input logic [7:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [15:0] imm);
    return {op, rd, rs, imm};
  endfunction

  function automatic logic [31:0] ins_r(input logic [7:0] op, input logic [3:0] rd,
                                        input logic [3:0] rs, input logic [3:0] rt);
    return {op, rd, rs, 12'h000, rt};
  endfunction

  task automatic clear_mem();
    for (int k = 0; k < 256; k++) mem[k] = (k >= 128) ? $urandom() : 32'h0;
  endtask

  // Instruction-level reference: expected port values per enabled cycle.
  task automatic model_run(input int pad);
    logic [31:0] pc, npc, ins, rdv, rsv, rtv, simm, y, r, ea;
    logic [7:0]  op;
    logic [3:0]  rd;
    exp_q.delete();
    for (int k = 0; k < 256; k++) m_mem[k] = mem[k];
    for (int k = 0; k < 16; k++) m_reg[k] = '0;
    pc = 32'h0;
    for (int step = 0; step < 1000; step++) begin
      ins  = m_mem[pc[9:2]];
      op   = ins[31:24];
      rd   = ins[23:20];
      rdv  = m_reg[rd];
      rsv  = m_reg[ins[19:16]];
      rtv  = m_reg[ins[3:0]];
      simm = {{16{ins[15]}}, ins[15:0]};
      ea   = (rsv + simm) & 32'hFFFF_FFFC;
      npc  = pc + 32'd4;
      exp_q.push_back({pc, 1'b0, 32'h0});   // fetch cycle
      exp_q.push_back({pc, 1'b0, 32'h0});   // execute cycle
      if (op == 8'hFF) begin
        for (int k = 0; k < pad; k++) exp_q.push_back({pc, 1'b0, 32'h0});
        break;
      end
      if (op[7:4] == 4'h1) begin
        y = op[3] ? simm : rtv;
        case (op[2:0])
          3'd0: r = rsv + y;
          3'd1: r = rsv - y;
          3'd2: r = rsv & y;
          3'd3: r = rsv | y;
          3'd4: r = rsv ^ y;
          3'd5: r = rsv << y[4:0];
          3'd6: r = rsv >> y[4:0];
          default: r = ($signed(rsv) < $signed(y)) ? 32'd1 : 32'd0;
        endcase
        if (rd != 4'd0) m_reg[rd] = r;
      end else begin
        case (op)
          8'h01: if (rd != 4'd0) m_reg[rd] = simm;
          8'h02: if (rd != 4'd0) m_reg[rd] = {ins[15:0], 16'h0};
          8'h20: begin
            exp_q.push_back({ea, 1'b0, 32'h0});
            if (rd != 4'd0) m_reg[rd] = m_mem[ea[9:2]];
          end
          8'h21: begin
            exp_q.push_back({ea, 1'b1, rdv});
            m_mem[ea[9:2]] = rdv;
          end
          8'h30: npc = ea;
          8'h31: if (rdv == rsv) npc = pc + 32'd4 + (simm << 2);
          8'h32: if (rdv != rsv) npc = pc + 32'd4 + (simm << 2);
          8'h33: begin
            if (rd != 4'd0) m_reg[rd] = pc + 32'd4;
            npc = pc + 32'd4 + (simm << 2);
          end
`ifdef C32_MUL_EN
          8'h40: if (rd != 4'd0) m_reg[rd] = rsv * rtv;
`endif
          default: ;
        endcase
      end
      pc = npc;
    end
  endtask

  // Reset for `edges` rising edges with ce low (reset must win over ce).
  task automatic reset_dut(input int edges);
    reset_n = 1'b0;
    ce      = 1'b0;
    repeat (edges) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // mode 0: ce always 1; mode 1: ce low for stall_len edges from sample stall_at;
  // mode 2: ce random (low about one edge in four).
  task automatic run_dut(input int n, input int mode, input int stall_at, input int stall_len);
    obs_q.delete();
    ce_q.delete();
    for (int k = 0; k < n; k++) begin
      obs_q.push_back({a, w, o});
      case (mode)
        1:       ce = !(k >= stall_at && k < stall_at + stall_len);
        2:       ce = ($urandom_range(0, 3) != 0);
        default: ce = 1'b1;
      endcase
      ce_q.push_back(ce);
      @(negedge clock);
    end
    ce = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_dut(2);
    n_checks++; if (a !== 32'h0) begin n_fail++; $display("FAIL reset_a got %h exp 00000000", a); end
    n_checks++; if (w !== 1'b0)  begin n_fail++; $display("FAIL reset_w got %b exp 0", w); end
    n_checks++; if (o !== 32'h0) begin n_fail++; $display("FAIL reset_o got %h exp 00000000", o); end
  endtask

  task automatic test_nops();
    logic [64:0] g;
    clear_mem();
    reset_dut(2);
    run_dut(12, 0, 0, 0);
    for (int k = 0; k < 12; k++) begin
      g = obs_q[k];
      n_checks++;
      if (g[64:33] !== 32'(4 * (k / 2)) || g[32] !== 1'b0) begin
        n_fail++;
        $display("FAIL nop_seq k=%0d got a=%h w=%b exp a=%h w=0", k, g[64:33], g[32], 32'(4 * (k / 2)));
      end
    end
  endtask

  task automatic test_add_store();
    logic [64:0] g, cur;
    int          n_w;
    clear_mem();
    mem[0] = ins_i(8'h01, 4'd1, 4'd0, 16'd5);
    mem[1] = ins_i(8'h01, 4'd2, 4'd0, 16'hFFFD);
    mem[2] = ins_r(8'h10, 4'd3, 4'd1, 4'd2);
    mem[3] = ins_i(8'h21, 4'd3, 4'd0, 16'h0040);
    mem[4] = ins_i(8'hFF, 4'd0, 4'd0, 16'h0);
    model_run(4);
    reset_dut(2);
    run_dut(exp_q.size(), 0, 0, 0);
    n_w = 0;
    cur = exp_q.pop_front();
    foreach (obs_q[k]) begin
      g = obs_q[k];
      n_checks++;
      if (g[64:32] !== cur[64:32] || (cur[32] && g[31:0] !== cur[31:0])) begin
        n_fail++;
        $display("FAIL add_trace k=%0d got a=%h w=%b o=%h exp a=%h w=%b o=%h",
                 k, g[64:33], g[32], g[31:0], cur[64:33], cur[32], cur[31:0]);
      end
      if (g[32] === 1'b1) begin
        n_w++;
        n_checks++;
        if (g[64:33] !== 32'h40 || g[31:0] !== 32'd2) begin
          n_fail++;
          $display("FAIL add_store_port got a=%h o=%h exp a=00000040 o=00000002", g[64:33], g[31:0]);
        end
      end
      if (ce_q[k] && exp_q.size() > 0) cur = exp_q.pop_front();
    end
    n_checks++; if (n_w != 1) begin n_fail++; $display("FAIL add_w_cycles got %0d exp 1", n_w); end
    n_checks++; if (mem[16] !== 32'd2) begin n_fail++; $display("FAIL add_mem got %h exp 00000002", mem[16]); end
  endtask

  task automatic test_lui_or_ld();
    logic [64:0] g, cur;
    clear_mem();
    mem[0] = ins_i(8'h02, 4'd1, 4'd0, 16'h1234);
    mem[1] = ins_i(8'h1B, 4'd1, 4'd1, 16'h5678);
    mem[2] = ins_i(8'h21, 4'd1, 4'd0, 16'h0040);
    mem[3] = ins_i(8'h20, 4'd4, 4'd0, 16'h0040);
    mem[4] = ins_i(8'h21, 4'd4, 4'd0, 16'h0044);
    mem[5] = ins_i(8'hFF, 4'd0, 4'd0, 16'h0);
    model_run(4);
    reset_dut(2);
    run_dut(exp_q.size(), 0, 0, 0);
    cur = exp_q.pop_front();
    foreach (obs_q[k]) begin
      g = obs_q[k];
      n_checks++;
      if (g[64:32] !== cur[64:32] || (cur[32] && g[31:0] !== cur[31:0])) begin
        n_fail++;
        $display("FAIL lui_trace k=%0d got a=%h w=%b o=%h exp a=%h w=%b o=%h",
                 k, g[64:33], g[32], g[31:0], cur[64:33], cur[32], cur[31:0]);
      end
      if (ce_q[k] && exp_q.size() > 0) cur = exp_q.pop_front();
    end
    n_checks++; if (mem[16] !== 32'h12345678) begin n_fail++; $display("FAIL lui_or_mem got %h exp 12345678", mem[16]); end
    n_checks++; if (mem[17] !== 32'h12345678) begin n_fail++; $display("FAIL ld_st_mem got %h exp 12345678", mem[17]); end
  endtask

  task automatic test_loop_jal();
    logic [64:0] g, cur;
    clear_mem();
    mem[0] = ins_i(8'h01, 4'd1, 4'd0, 16'd3);        // r1 = 3
    mem[1] = ins_i(8'h01, 4'd2, 4'd0, 16'd0);        // r2 = 0
    mem[2] = ins_i(8'h18, 4'd2, 4'd2, 16'd1);        // loop: r2 += 1
    mem[3] = ins_i(8'h19, 4'd1, 4'd1, 16'd1);        // r1 -= 1
    mem[4] = ins_i(8'h32, 4'd1, 4'd0, 16'hFFFD);     // BNE r1,r0 -> 0x08
    mem[5] = ins_i(8'h33, 4'd15, 4'd0, 16'd2);       // JAL r15 -> 0x20
    mem[6] = ins_i(8'h21, 4'd2, 4'd0, 16'h0040);     // ST r2
    mem[7] = ins_i(8'hFF, 4'd0, 4'd0, 16'h0);
    mem[8] = ins_i(8'h21, 4'd15, 4'd0, 16'h0044);    // ST r15
    mem[9] = ins_i(8'h30, 4'd0, 4'd15, 16'h0);       // JR r15
    model_run(4);
    reset_dut(2);
    run_dut(exp_q.size(), 0, 0, 0);
    cur = exp_q.pop_front();
    foreach (obs_q[k]) begin
      g = obs_q[k];
      n_checks++;
      if (g[64:32] !== cur[64:32] || (cur[32] && g[31:0] !== cur[31:0])) begin
        n_fail++;
        $display("FAIL loop_trace k=%0d got a=%h w=%b o=%h exp a=%h w=%b o=%h",
                 k, g[64:33], g[32], g[31:0], cur[64:33], cur[32], cur[31:0]);
      end
      if (ce_q[k] && exp_q.size() > 0) cur = exp_q.pop_front();
    end
    n_checks++; if (mem[16] !== 32'd3)     begin n_fail++; $display("FAIL loop_count got %h exp 00000003", mem[16]); end
    n_checks++; if (mem[17] !== 32'h18)    begin n_fail++; $display("FAIL jal_link got %h exp 00000018", mem[17]); end
  endtask

  task automatic test_halt_reset();
    logic [64:0] g, cur;
    logic [31:0] exp_a [5];
    logic        exp_w [5];
    exp_a = '{32'h0, 32'h0, 32'h4, 32'h4, 32'h48};
    exp_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    clear_mem();
    mem[0] = ins_i(8'h01, 4'd1, 4'd0, 16'h0055);
    mem[1] = ins_i(8'h21, 4'd1, 4'd0, 16'h0048);
    mem[2] = ins_i(8'hFF, 4'd0, 4'd0, 16'h0);
    model_run(100);
    reset_dut(2);
    run_dut(exp_q.size(), 0, 0, 0);
    cur = exp_q.pop_front();
    foreach (obs_q[k]) begin
      g = obs_q[k];
      n_checks++;
      if (g[64:32] !== cur[64:32] || (cur[32] && g[31:0] !== cur[31:0])) begin
        n_fail++;
        $display("FAIL halt_trace k=%0d got a=%h w=%b o=%h exp a=%h w=%b o=%h",
                 k, g[64:33], g[32], g[31:0], cur[64:33], cur[32], cur[31:0]);
      end
      if (ce_q[k] && exp_q.size() > 0) cur = exp_q.pop_front();
    end
    n_checks++; if (a !== 32'h8) begin n_fail++; $display("FAIL halt_a got %h exp 00000008", a); end
    reset_dut(1);
    n_checks++; if (a !== 32'h0) begin n_fail++; $display("FAIL halt_rst_a got %h exp 00000000", a); end
    n_checks++; if (o !== 32'h0) begin n_fail++; $display("FAIL halt_rst_o got %h exp 00000000", o); end
    run_dut(5, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      g = obs_q[k];
      n_checks++;
      if (g[64:33] !== exp_a[k] || g[32] !== exp_w[k]) begin
        n_fail++;
        $display("FAIL restart k=%0d got a=%h w=%b exp a=%h w=%b", k, g[64:33], g[32], exp_a[k], exp_w[k]);
      end
    end
  endtask

  task automatic test_ce_ld();
    logic [64:0] g, cur;
    logic [31:0] data;
    clear_mem();
    data   = mem[128];
    mem[0] = ins_i(8'h01, 4'd2, 4'd0, 16'h1111);
    mem[1] = ins_i(8'h20, 4'd1, 4'd0, 16'h0200);
    mem[2] = ins_i(8'h21, 4'd1, 4'd0, 16'h0204);
    mem[3] = ins_i(8'hFF, 4'd0, 4'd0, 16'h0);
    model_run(4);
    reset_dut(2);
    // Sample 4 is the MEM cycle of the LD; hold ce low for 5 edges there.
    run_dut(exp_q.size() + 5, 1, 4, 5);
    cur = exp_q.pop_front();
    foreach (obs_q[k]) begin
      g = obs_q[k];
      n_checks++;
      if (g[64:32] !== cur[64:32] || (cur[32] && g[31:0] !== cur[31:0])) begin
        n_fail++;
        $display("FAIL ce_trace k=%0d got a=%h w=%b o=%h exp a=%h w=%b o=%h",
                 k, g[64:33], g[32], g[31:0], cur[64:33], cur[32], cur[31:0]);
      end
      if (ce_q[k] && exp_q.size() > 0) cur = exp_q.pop_front();
    end
    for (int k = 5; k < 10; k++) begin
      g = obs_q[k];
      n_checks++;
      if (g[64:33] !== 32'h200 || g[32] !== 1'b0) begin
        n_fail++;
        $display("FAIL ce_hold k=%0d got a=%h w=%b exp a=00000200 w=0", k, g[64:33], g[32]);
      end
    end
    n_checks++; if (mem[129] !== data) begin n_fail++; $display("FAIL ce_ld_data got %h exp %h", mem[129], data); end
  endtask

  task automatic test_mul();
    logic [64:0] g, cur;
    logic [31:0] want;
`ifdef C32_MUL_EN
    want = 32'd42;
`else
    want = 32'd99;
`endif
    clear_mem();
    mem[0] = ins_i(8'h01, 4'd1, 4'd0, 16'd7);
    mem[1] = ins_i(8'h01, 4'd2, 4'd0, 16'd6);
    mem[2] = ins_i(8'h01, 4'd3, 4'd0, 16'd99);
    mem[3] = ins_r(8'h40, 4'd3, 4'd1, 4'd2);
    mem[4] = ins_i(8'h21, 4'd3, 4'd0, 16'h0040);
    mem[5] = ins_i(8'hFF, 4'd0, 4'd0, 16'h0);
    model_run(4);
    reset_dut(2);
    run_dut(exp_q.size(), 0, 0, 0);
    cur = exp_q.pop_front();
    foreach (obs_q[k]) begin
      g = obs_q[k];
      n_checks++;
      if (g[64:32] !== cur[64:32] || (cur[32] && g[31:0] !== cur[31:0])) begin
        n_fail++;
        $display("FAIL mul_trace k=%0d got a=%h w=%b o=%h exp a=%h w=%b o=%h",
                 k, g[64:33], g[32], g[31:0], cur[64:33], cur[32], cur[31:0]);
      end
      if (ce_q[k] && exp_q.size() > 0) cur = exp_q.pop_front();
    end
    n_checks++; if (mem[16] !== want) begin n_fail++; $display("FAIL mul_result got %h exp %h", mem[16], want); end
  endtask

  task automatic test_reset_mid_store();
    bit found;
    clear_mem();
    mem[0] = ins_i(8'h01, 4'd1, 4'd0, 16'd9);
    mem[1] = ins_i(8'h21, 4'd1, 4'd0, 16'h0040);
    mem[2] = ins_i(8'hFF, 4'd0, 4'd0, 16'h0);
    reset_dut(2);
    ce = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (w === 1'b1) found = 1'b1;
      else @(negedge clock);
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL mid_store_timeout got no store in 20 cycles exp store");
    end else begin
      reset_n = 1'b0;
      @(negedge clock);
      n_checks++; if (w !== 1'b0)  begin n_fail++; $display("FAIL mid_store_w got %b exp 0", w); end
      n_checks++; if (a !== 32'h0) begin n_fail++; $display("FAIL mid_store_a got %h exp 00000000", a); end
      reset_n = 1'b1;
    end
  endtask

  task automatic test_random();
    logic [64:0] g, cur;
    int          pw;
    logic [3:0]  r1, r2, r3;
    for (int iter = 0; iter < 6; iter++) begin
      clear_mem();
      pw = 0;
      for (int r = 1; r < 16; r++) begin
        mem[pw] = ins_i(8'h01, 4'(r), 4'd0, 16'($urandom()));
        pw++;
      end
      for (int n = 0; n < 40; n++) begin
        r1 = 4'($urandom_range(0, 15));
        r2 = 4'($urandom_range(0, 15));
        r3 = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 9))
          0: mem[pw] = ins_i(8'h01, r1, 4'd0, 16'($urandom()));
          1: mem[pw] = ins_i(8'h02, r1, 4'd0, 16'($urandom()));
          2, 3: mem[pw] = ins_r(8'(8'h10 + $urandom_range(0, 7)), r1, r2, r3);
          4, 5: mem[pw] = ins_i(8'(8'h18 + $urandom_range(0, 7)), r1, r2, 16'($urandom()));
          6: mem[pw] = ins_i(8'h20, r1, 4'd0, 16'(16'h200 + 4 * $urandom_range(0, 127) + $urandom_range(0, 3)));
          7: mem[pw] = ins_i(8'h21, r1, 4'd0, 16'(16'h200 + 4 * $urandom_range(0, 127) + $urandom_range(0, 3)));
          8: mem[pw] = ins_i(8'(8'h31 + $urandom_range(0, 2)), r1, r2, 16'($urandom_range(0, 3)));
          default: case ($urandom_range(0, 3))
            0: mem[pw] = ins_r(8'h40, r1, r2, r3);
            1: mem[pw] = ins_i(8'h05, r1, r2, 16'($urandom()));
            2: mem[pw] = ins_i(8'h22, r1, r2, 16'($urandom()));
            default: mem[pw] = 32'h0;
          endcase
        endcase
        pw++;
      end
      for (int r = 1; r < 16; r++) begin
        mem[pw] = ins_i(8'h21, 4'(r), 4'd0, 16'(16'h200 + 4 * r));
        pw++;
      end
      mem[pw] = ins_i(8'hFF, 4'd0, 4'd0, 16'h0);
      model_run(4);
      reset_dut(2);
      run_dut(2 * exp_q.size() + 20, 2, 0, 0);
      cur = exp_q.pop_front();
      foreach (obs_q[k]) begin
        g = obs_q[k];
        n_checks++;
        if (g[64:32] !== cur[64:32] || (cur[32] && g[31:0] !== cur[31:0])) begin
          n_fail++;
          $display("FAIL rand%0d_trace k=%0d got a=%h w=%b o=%h exp a=%h w=%b o=%h",
                   iter, k, g[64:33], g[32], g[31:0], cur[64:33], cur[32], cur[31:0]);
        end
        if (ce_q[k] && exp_q.size() > 0) cur = exp_q.pop_front();
      end
      for (int k = 128; k < 256; k++) begin
        n_checks++;
        if (mem[k] !== m_mem[k]) begin
          n_fail++;
          $display("FAIL rand%0d_mem word %0d got %h exp %h", iter, k, mem[k], m_mem[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nops();
    test_add_store();
    test_lui_or_ld();
    test_loop_jal();
    test_halt_reset();
    test_ce_ld();
    test_mul();
    test_reset_mid_store();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
